// File: rtl/wb_tgt_mem_pkg.sv
// wb_tgt_mem shared types: FSM state encodings and the queue-entry bundle.
// Entry fields are sized for the widest supported bus (32/32/4).
package wb_tgt_mem_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_RESET = 2'b00;
  localparam fsm_state_t ST_IDLE  = 2'b01;
  localparam fsm_state_t ST_BUSY  = 2'b10;

  localparam int Q_ADR_MAX = 32;
  localparam int Q_DAT_MAX = 32;
  localparam int Q_SEL_MAX = 4;

  typedef struct packed {
    logic                 we;
    logic [Q_SEL_MAX-1:0] sel;
    logic [Q_ADR_MAX-1:0] adr;
    logic [Q_DAT_MAX-1:0] dat;
  } q_entry_t;

endpackage

// File: rtl/wb_tgt_mem_queue.sv
// Pending-request FIFO with per-entry saturating age counters.
// Ports: clk_i, sync_rst_i, flush_i, push_i/push_ent_i, pop_i,
//   head_o, head_vld_o, head_ripe_o (old enough to retire),
//   head_last_o (one entry left), full_o (registered).
module wb_tgt_mem_queue
  import wb_tgt_mem_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 3
) (
  input  logic     clk_i,
  input  logic     sync_rst_i,
  input  logic     flush_i,
  input  logic     push_i,
  input  q_entry_t push_ent_i,
  input  logic     pop_i,
  output q_entry_t head_o,
  output logic     head_vld_o,
  output logic     head_ripe_o,
  output logic     head_last_o,
  output logic     full_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(LATENCY + 1);

  q_entry_t        ent_q  [DEPTH];
  q_entry_t        ent_d  [DEPTH];
  q_entry_t        sh_ent [DEPTH];
  logic [AW-1:0]   age_q  [DEPTH];
  logic [AW-1:0]   age_d  [DEPTH];
  logic [AW-1:0]   sh_age [DEPTH];
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_pop;
  logic            full_q;

  function automatic logic [AW-1:0] age_inc(
    input logic [AW-1:0] a
  );
    return (a == AW'(LATENCY)) ? a : a + 1'b1;
  endfunction

  // Slot i after a pop takes slot i+1; top slot
  // keeps stale content, masked by the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_sh
    if (i < DEPTH - 1) begin : g_mid
      assign sh_ent[i] = ent_q[i+1];
      assign sh_age[i] = age_q[i+1];
    end else begin : g_top
      assign sh_ent[i] = ent_q[i];
      assign sh_age[i] = age_q[i];
    end
  end

  always_comb begin
    cnt_pop = cnt_q - CW'(pop_i);
    cnt_d   = cnt_pop + CW'(push_i);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = pop_i ? sh_ent[i] : ent_q[i];
      age_d[i] = age_inc(pop_i ? sh_age[i] : age_q[i]);
      // The accept edge counts as the first cycle of age.
      if (push_i && cnt_pop == CW'(i)) begin
        ent_d[i] = push_ent_i;
        age_d[i] = AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i || flush_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
      age_q[i] <= age_d[i];
    end
  end

  assign head_o      = ent_q[0];
  assign head_vld_o  = (cnt_q != '0);
  assign head_ripe_o = (age_q[0] >= AW'(LATENCY - 1));
  assign head_last_o = (cnt_q == CW'(1));
  assign full_o      = full_q;

endmodule

// File: rtl/wb_tgt_mem.sv
// Wishbone pipelined target with a small memory and fixed min latency.
// Ports: clk_i, sync_rst_i, tgt_* bus, tb_fsm_* status. WB_TGT_MEM_ERR_EN: err on out-of-range adr.
module wb_tgt_mem
  import wb_tgt_mem_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = 2,
  parameter int MEM_AW    = 4,
  parameter int DEPTH     = 2,
  parameter int LATENCY   = 3
) (
  input  logic                 clk_i,
  input  logic                 sync_rst_i,
  input  logic                 tgt_cyc_i,
  input  logic                 tgt_stb_i,
  input  logic                 tgt_we_i,
  input  logic [SEL_WIDTH-1:0] tgt_sel_i,
  input  logic [ADR_WIDTH-1:0] tgt_adr_i,
  input  logic [DAT_WIDTH-1:0] tgt_dat_i,
  output logic                 tgt_ack_o,
  output logic                 tgt_err_o,
  output logic                 tgt_rty_o,
  output logic                 tgt_stall_o,
  output logic [DAT_WIDTH-1:0] tgt_dat_o,
  output logic                 tb_fsm_reset,
  output logic                 tb_fsm_idle,
  output logic                 tb_fsm_busy
);

  localparam int LANE_W = DAT_WIDTH / SEL_WIDTH;
  localparam int WORDS  = 2 ** MEM_AW;

  q_entry_t             push_ent;
  q_entry_t             head;
  logic                 head_vld;
  logic                 head_ripe;
  logic                 head_last;
  logic                 q_full;
  logic                 accept;
  logic                 pop;
  logic                 flush;
  logic                 bad;
  logic [MEM_AW-1:0]    idx;
  logic [DAT_WIDTH-1:0] wr_word;
  logic [DAT_WIDTH-1:0] mem_q [WORDS];
  logic                 ack_q;
  logic                 err_q;
  logic [DAT_WIDTH-1:0] dat_q;
  fsm_state_t           state_q;
  fsm_state_t           state_d;
  logic                 unused_head;

  assign flush  = ~tgt_cyc_i;
  assign accept = tgt_cyc_i & tgt_stb_i & ~q_full
                & ~sync_rst_i;
  assign pop    = tgt_cyc_i & head_vld & head_ripe
                & ~sync_rst_i;
  assign idx    = head.adr[MEM_AW-1:0];

  always_comb begin
    push_ent                    = '0;
    push_ent.we                 = tgt_we_i;
    push_ent.sel[SEL_WIDTH-1:0] = tgt_sel_i;
    push_ent.adr[ADR_WIDTH-1:0] = tgt_adr_i;
    push_ent.dat[DAT_WIDTH-1:0] = tgt_dat_i;
  end

  wb_tgt_mem_queue #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk_i       (clk_i),
    .sync_rst_i  (sync_rst_i),
    .flush_i     (flush),
    .push_i      (accept),
    .push_ent_i  (push_ent),
    .pop_i       (pop),
    .head_o      (head),
    .head_vld_o  (head_vld),
    .head_ripe_o (head_ripe),
    .head_last_o (head_last),
    .full_o      (q_full)
  );

`ifdef WB_TGT_MEM_ERR_EN
  assign bad = |head.adr[Q_ADR_MAX-1:MEM_AW];
`else
  assign bad = 1'b0;
`endif

  // Upper entry bits exist only for wider buses.
  assign unused_head = ^{head.adr, head.dat, head.sel};

  always_comb begin
    wr_word = mem_q[idx];
    for (int l = 0; l < SEL_WIDTH; l++) begin
      if (head.sel[l]) begin
        wr_word[l*LANE_W +: LANE_W] =
          head.dat[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      for (int w = 0; w < WORDS; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      ack_q <= pop & ~bad;
      err_q <= pop & bad;
      dat_q <= (pop & ~head.we & ~bad) ?
               mem_q[idx] : '0;
      if (pop & head.we & ~bad) begin
        mem_q[idx] <= wr_word;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (flush || (pop && !accept && head_last))
          state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) state_q <= ST_RESET;
    else            state_q <= state_d;
  end

  assign tgt_ack_o    = ack_q;
  assign tgt_err_o    = err_q;
  assign tgt_rty_o    = 1'b0;
  assign tgt_stall_o  = q_full;
  assign tgt_dat_o    = dat_q;
  assign tb_fsm_reset = (state_q == ST_RESET);
  assign tb_fsm_idle  = (state_q == ST_IDLE);
  assign tb_fsm_busy  = (state_q == ST_BUSY);

endmodule

// File: doc/wb_tgt_mem.md
WB_TGT_MEM -- requirements
Module: wb_tgt_mem

Interface
REQ-001 Parameter ADR_WIDTH, default 16, address bus width.
REQ-002 Parameter DAT_WIDTH, default 16, data bus width.
REQ-003 Parameter SEL_WIDTH, default 2, byte selects (DAT_WIDTH/SEL_WIDTH bits each).
REQ-004 Parameter MEM_AW, default 4, memory word-address width (2**MEM_AW words).
REQ-005 Parameter DEPTH, default 2, pending-request queue depth (>=1).
REQ-006 Parameter LATENCY, default 3, minimum response latency in cycles (>=1).
REQ-007 clk_i  in  1  module clock; sync_rst_i  in  1  reset, synchronous, active-high.
REQ-008 tgt_cyc_i, tgt_stb_i, tgt_we_i  in  1 each  bus cycle, access request, write enable.
REQ-009 tgt_sel_i  in  SEL_WIDTH; tgt_adr_i  in  ADR_WIDTH; tgt_dat_i  in  DAT_WIDTH  write data.
REQ-010 tgt_ack_o, tgt_err_o, tgt_rty_o, tgt_stall_o  out  1 each  termination and access delay.
REQ-011 tgt_dat_o  out  DAT_WIDTH  read data.
REQ-012 tb_fsm_reset, tb_fsm_idle, tb_fsm_busy  out  1 each  testbench FSM status.

Function
REQ-013 Request accepted at a rising edge iff tgt_cyc_i & tgt_stb_i & ~tgt_stall_o; accepted request (we, sel, adr, dat) is pushed into the queue.
REQ-014 tgt_stall_o SHALL be registered, high iff the queue holds DEPTH entries.
REQ-015 Each entry carries an age counter saturating at LATENCY, incremented every cycle.
REQ-016 The head entry is retired at the edge where its age >= LATENCY-1; termination is registered and visible in the following cycle, so a request accepted at edge k terminates in the cycle after edge k+LATENCY-1 at the earliest.
REQ-017 Terminations SHALL be in acceptance order, at most one per cycle; tgt_ack_o/tgt_err_o are single-cycle pulses, never both high.
REQ-018 Write retire: memory word adr[MEM_AW-1:0] updated only in lanes with sel bit set; tgt_dat_o = 0.
REQ-019 Read retire: tgt_dat_o = memory word at retire edge (includes writes retired at earlier edges); sel ignored.
REQ-020 tgt_dat_o = 0 in every cycle without termination.
REQ-021 tgt_rty_o SHALL be constant 0.
REQ-022 Push and pop at the same edge SHALL both take effect; a full queue that retires its head deasserts stall in the next cycle.
REQ-023 tgt_cyc_i low at an edge: queue flushed, pending entries neither terminated nor applied to memory, no request accepted.
REQ-024 FSM states RESET, IDLE (queue empty), BUSY (queue non-empty); RESET->IDLE unconditionally; IDLE->BUSY on accept; BUSY->IDLE on pop without push leaving queue empty, or on flush.
REQ-025 tb_fsm_reset/idle/busy SHALL be high exactly in RESET / IDLE / BUSY.

Reset
REQ-026 sync_rst_i high at an edge: FSM to RESET, queue emptied, all memory words 0, tgt_ack_o, tgt_err_o, tgt_stall_o low, tgt_dat_o 0.
REQ-027 Reset mid-operation discards pending entries without termination or memory update; no request accepted while sync_rst_i is high.

Configuration
REQ-028 Macro WB_TGT_MEM_ERR_EN defined: request with any tgt_adr_i bit above MEM_AW-1 set retires with tgt_err_o instead of tgt_ack_o, no memory update, tgt_dat_o 0.
REQ-029 Macro undefined: upper address bits ignored (memory aliases), every retire uses tgt_ack_o, tgt_err_o constant 0.

Structure
REQ-030 Package wb_tgt_mem_pkg SHALL hold the FSM state typedef with encodings RESET=2'b00, IDLE=2'b01, BUSY=2'b10, and the queue-entry struct typedef.
REQ-031 Queue with per-entry age counters SHALL be a sub-module wb_tgt_mem_queue; memory, retire logic and FSM stay in wb_tgt_mem.

Verification
REQ-032 Reset, then single write adr 0x0003 dat 0xBEEF sel 2'b11 at edge 0 -> tgt_ack_o high only in cycle after edge 2; read of 0x0003 returns 0xBEEF.
REQ-033 Write 0x1234 then write 0xAB00 sel 2'b10 to adr 5, then read adr 5 -> read returns 0xAB34.
REQ-034 Back-to-back requests with cyc/stb held high, DEPTH=2, LATENCY=3 -> tgt_stall_o high after two accepts, all requests terminated in order, no request lost or duplicated.
REQ-035 Two reads queued, tgt_cyc_i dropped for one cycle before retire -> no ack, FSM returns to IDLE, memory unchanged.
REQ-036 With WB_TGT_MEM_ERR_EN, write adr 0x0010 -> tgt_err_o pulse, tgt_ack_o low, word 0 still reads 0; without macro, same write -> ack and word 0 updated.
REQ-037 sync_rst_i asserted while queue is full -> next cycle stall low, tb_fsm_reset high, no termination, all words read 0.
